// File: rtl/bus_arbiter4_pkg.sv
// Shared constants plus the round-robin pick helpers for the 4-way bus arbiter.
// Pure declarations: no state and no timing.
package constants;

   localparam int WORD_LENGTH = 32;
   localparam int ARB_PORTS   = 4;
   localparam int ARB_SEL_W   = 2;

   typedef struct packed {
      logic                 found;
      logic [ARB_SEL_W-1:0] idx;
   } pick_t;

   function automatic logic [ARB_PORTS-1:0] onehot4(input logic [ARB_SEL_W-1:0] i);
      return {{(ARB_PORTS-1){1'b0}}, 1'b1} << i;
   endfunction

   // Scan ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap); the first set mask bit wins.
   function automatic pick_t rr_pick(input logic [ARB_SEL_W-1:0] ptr,
                                     input logic [ARB_PORTS-1:0] mask);
      pick_t                r;
      logic [ARB_SEL_W-1:0] cand;
      logic [ARB_SEL_W-1:0] off;
      r = '0;
      for (int k = ARB_PORTS - 1; k >= 0; k--) begin
         off  = k[ARB_SEL_W-1:0];
         cand = ptr + off;
         if (mask[cand]) begin
            r.found = 1'b1;
            r.idx   = cand;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_arbiter4_mux4.sv
// Four-input word mux. Combinational: zero latency, and it never stalls.
module _mux4
   import constants::*;
#(
   parameter int n = WORD_LENGTH
) (
   input  logic [ARB_SEL_W-1:0] sel,
   input  logic [n-1:0]         in0,
   input  logic [n-1:0]         in1,
   input  logic [n-1:0]         in2,
   input  logic [n-1:0]         in3,
   output logic [n-1:0]         out
);

   always_comb begin
      out = in0;
      case (sel)
         2'd0:    out = in0;
         2'd1:    out = in1;
         2'd2:    out = in2;
         default: out = in3;
      endcase
   end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin 4-way bus arbiter with hold-until-release ownership and optional forced rotation.
// A request is granted one cycle later; a waiting requester waits until the owner releases or is preempted.
module bus_arbiter4
   import constants::*;
#(
   parameter int n        = WORD_LENGTH,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ARB_PORTS-1:0] req,
   input  logic [n-1:0]         in0,
   input  logic [n-1:0]         in1,
   input  logic [n-1:0]         in2,
   input  logic [n-1:0]         in3,
   output logic [ARB_PORTS-1:0] gnt,
   output logic [ARB_SEL_W-1:0] sel,
   output logic                 busy,
   output logic [n-1:0]         bus_data,
   output logic                 preempted
);

   localparam int CW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

   typedef enum logic {IDLE, OWN} state_t;

   state_t               state_q;
   logic [ARB_PORTS-1:0] gnt_q;
   logic [ARB_SEL_W-1:0] sel_q;
   logic [ARB_SEL_W-1:0] ptr_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q;
   logic                 pre_q;

   logic [ARB_SEL_W-1:0] ptr_d;
   logic [ARB_PORTS-1:0] others;
   pick_t                pick_idle;
   pick_t                pick_rot;
   logic                 preempt;

   assign ptr_d     = sel_q + 2'd1;
   assign others    = req & ~onehot4(sel_q);
   assign pick_idle = rr_pick(ptr_q, req);
   assign pick_rot  = rr_pick(ptr_d, others);
   // The counter parks at HOLD_LAST, so a late competitor still triggers rotation on its first edge.
   assign preempt   = (MAX_HOLD > 0) && (cnt_q == HOLD_LAST) && (others != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         pre_q   <= 1'b0;
      end else begin
         pre_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_idle.found) begin
                  state_q <= OWN;
                  gnt_q   <= onehot4(pick_idle.idx);
                  sel_q   <= pick_idle.idx;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  gnt_q  <= '0;
                  busy_q <= 1'b0;
               end
            end
            OWN: begin
               if (!req[sel_q]) begin
                  ptr_q <= ptr_d;
                  cnt_q <= '0;
                  if (pick_rot.found) begin
                     gnt_q <= onehot4(pick_rot.idx);
                     sel_q <= pick_rot.idx;
                  end else begin
                     state_q <= IDLE;
                     gnt_q   <= '0;
                     busy_q  <= 1'b0;
                  end
               end else if (preempt) begin
                  ptr_q <= ptr_d;
                  cnt_q <= '0;
                  gnt_q <= onehot4(pick_rot.idx);
                  sel_q <= pick_rot.idx;
                  pre_q <= 1'b1;
               end else if (cnt_q != HOLD_LAST) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign busy      = busy_q;
   assign preempted = pre_q;

   _mux4 #(n) u_mux (
      .sel (sel_q),
      .in0 (in0),
      .in1 (in1),
      .in2 (in2),
      .in3 (in3),
      .out (bus_data)
   );

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4 (MAX_HOLD=4): vector table through a scoreboard, then a random invariant run.
module tb_bus_arbiter4;
   import constants::*;

   localparam int N = 32;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       pre;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       pre;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   req = 4'b0000;
   logic [N-1:0] din [4];
   logic [3:0]   gnt;
   logic [1:0]   sel;
   logic         busy;
   logic [N-1:0] bus_data;
   logic         preempted;

   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   bus_arbiter4 #(.n(N), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .in0       (din[0]),
      .in1       (din[1]),
      .in2       (din[2]),
      .in3       (din[3]),
      .gnt       (gnt),
      .sel       (sel),
      .busy      (busy),
      .bus_data  (bus_data),
      .preempted (preempted)
   );

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                      input logic [1:0] s, input logic b, input logic p);
      vec_t v;
      v.rst = r; v.req = rq; v.gnt = g; v.sel = s; v.busy = b; v.pre = p;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return one << (i % 4);
   endfunction

   initial begin
      exp_t e;
      vec_t v;
      logic [3:0] g;

      for (int i = 0; i < 4; i++) din[i] = 32'hA5A5_0000 + i;

      // Reset, then a single request from idle, then release to idle (ptr becomes 3).
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b0100, 4'b0100, 2, 1, 0);
      add(0, 4'b0100, 4'b0100, 2, 1, 0);
      add(0, 4'b0000, 4'b0000, 2, 0, 0);
      // Lone owner 1 releases (ptr=2); the wrapped search then picks 0 over 1.
      add(0, 4'b0010, 4'b0010, 1, 1, 0);
      add(0, 4'b0010, 4'b0010, 1, 1, 0);
      add(0, 4'b0000, 4'b0000, 1, 0, 0);
      add(0, 4'b0011, 4'b0001, 0, 1, 0);
      // Fairness: all request, each owner holds 3 cycles then drops for one.
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b1111, 4'b0001, 0, 1, 0);
      for (int o = 0; o < 4; o++) begin
         add(0, 4'b1111, oh(o), 2'(o), 1, 0);
         add(0, 4'b1111, oh(o), 2'(o), 1, 0);
         add(0, 4'b1111 & ~oh(o), oh(o + 1), 2'((o + 1) % 4), 1, 0);
      end
      // Preemption on the 4th owned edge, single-cycle pulse, owner 0 returns.
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      add(0, 4'b0001, 4'b0001, 0, 1, 0);
      add(0, 4'b0001, 4'b0001, 0, 1, 0);
      add(0, 4'b1001, 4'b0001, 0, 1, 0);
      add(0, 4'b1001, 4'b0001, 0, 1, 0);
      add(0, 4'b1001, 4'b1000, 3, 1, 1);
      add(0, 4'b1001, 4'b1000, 3, 1, 0);
      add(0, 4'b0001, 4'b0001, 0, 1, 0);
      // Lone owner is never preempted; a late competitor wins on its first edge.
      add(1, 4'b0000, 4'b0000, 0, 0, 0);
      for (int i = 0; i < 20; i++) add(0, 4'b0010, 4'b0010, 1, 1, 0);
      add(0, 4'b0110, 4'b0100, 2, 1, 1);
      add(0, 4'b0010, 4'b0010, 1, 1, 0);
      // Owner 3 via rotation (ptr=2), reset mid-grant must clear ptr to 0.
      add(0, 4'b1000, 4'b1000, 3, 1, 0);
      add(1, 4'b1000, 4'b0000, 0, 0, 0);
      add(0, 4'b1001, 4'b0001, 0, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         reset = v.rst;
         req   = v.req;
         e.gnt = v.gnt; e.sel = v.sel; e.busy = v.busy; e.pre = v.pre;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty step=%0d got=0 want=1", i);
         end else begin
            e = sb.pop_front();
            chk("gnt", i, 32'(gnt), 32'(e.gnt));
            chk("sel", i, 32'(sel), 32'(e.sel));
            chk("busy", i, 32'(busy), 32'(e.busy));
            chk("preempted", i, 32'(preempted), 32'(e.pre));
            if (e.busy) chk("bus_data", i, bus_data, din[e.sel]);
         end
      end

      // Random requests: grant stays one-hot/zero and consistent with sel, busy and the mux.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         reset = 1'b0;
         req   = 4'($urandom_range(0, 15));
         @(posedge clk);
         #1;
         g = gnt;
         chk("onehot", 1000 + i, 32'(g & (g - 4'd1)), 32'd0);
         chk("busy_vs_gnt", 1000 + i, 32'(busy), 32'(g != 4'b0000));
         if (busy) begin
            chk("gnt_vs_sel", 1000 + i, 32'(g), 32'(oh(int'(sel))));
            chk("mux", 1000 + i, bus_data, din[sel]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
